// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO management-frame transmitter.
package mdio_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_FRAME    = 2'd2,
    S_DONE     = 2'd3
  } mdio_state_e;

  localparam int FRAME_BITS = 32;
  localparam int CNT_W      = 8;

  localparam int ST_MSB    = 31;
  localparam int ST_LSB    = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHYAD_MSB = 27;
  localparam int PHYAD_LSB = 23;
  localparam int REGAD_MSB = 22;
  localparam int REGAD_LSB = 18;
  localparam int TA_MSB    = 17;
  localparam int TA_LSB    = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_READ     = 2'b10;
  localparam logic [1:0] ST_CLAUSE22 = 2'b01;

  // Anything other than OP_READ is sent verbatim and handled as a write.
  function automatic logic is_read_op(input logic [FRAME_BITS-1:0] frame);
    return frame[OP_MSB:OP_LSB] == OP_READ;
  endfunction

endpackage

// File: rtl/mdio_bit_timer.sv
// MDC phase generator and bit down-counter; one bit spans two clk cycles.
module mdio_bit_timer
  import mdio_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             mdc,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             bit_end,
  output logic             last_bit
);

  // The phase flop doubles as MDC, so the clock output is registered.
  always_comb begin
    bit_end  = en & mdc;
    last_bit = bit_end && (cnt == '0);
    cnt_nxt  = cnt;
    if (load)
      cnt_nxt = load_val;
    else if (bit_end)
      cnt_nxt = cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc <= 1'b0;
      cnt <= '0;
    end else begin
      mdc <= en ? ~mdc : 1'b0;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/mdio_transmitter.sv
// MDIO station-management initiator: preamble + 32-bit frame out, 16-bit read capture.
//
// state    | meaning
// S_IDLE   | line released, waiting for mdio_start
// S_PREAMBLE | driving PREAMBLE_BITS logic-1 bits
// S_FRAME  | shifting frame bits 31..0; read frames release the line from TA
// S_DONE   | one-cycle end-of-frame strobe; may accept the next frame
module mdio_transmitter
  import mdio_pkg::*;
#(
  parameter int PREAMBLE_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mdio_start,
  input  logic [FRAME_BITS-1:0] t_data,
  input  logic                  mdio_in,
  output logic                  mdc,
  output logic                  mdio_out,
  output logic                  mdio_oe,
  output logic [15:0]           rd_data,
  output logic                  data_rdy,
  output logic                  mdio_done,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] TA_BIT     = CNT_W'(TA_MSB);
  localparam logic [CNT_W-1:0] DATA_BITS  = CNT_W'(DATA_MSB + 1);

  mdio_state_e           state, state_nxt;
  logic [FRAME_BITS-1:0] frame_q;
  logic [15:0]           shreg;
  logic                  is_read;
  logic                  timer_en, load;
  logic [CNT_W-1:0]      load_val;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  bit_end, last_bit;
  logic                  accept;

  assign is_read  = is_read_op(frame_q);
  assign timer_en = (state == S_PREAMBLE) || (state == S_FRAME);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = PRE_LOAD;
    accept    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mdio_start) begin
          state_nxt = S_PREAMBLE;
          load      = 1'b1;
          accept    = 1'b1;
        end
      end
      S_PREAMBLE: begin
        if (last_bit) begin
          state_nxt = S_FRAME;
          load      = 1'b1;
          load_val  = FRAME_LOAD;
        end
      end
      S_FRAME: begin
        if (last_bit)
          state_nxt = S_DONE;
      end
      S_DONE: begin
        // Accepting here gives back-to-back frames with no idle bit.
        if (mdio_start) begin
          state_nxt = S_PREAMBLE;
          load      = 1'b1;
          accept    = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  mdio_bit_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (timer_en),
    .load     (load),
    .load_val (load_val),
    .mdc      (mdc),
    .cnt      (cnt),
    .cnt_nxt  (cnt_nxt),
    .bit_end  (bit_end),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      frame_q   <= '0;
      shreg     <= '0;
      rd_data   <= '0;
      data_rdy  <= 1'b0;
      mdio_done <= 1'b0;
      busy      <= 1'b0;
      mdio_out  <= 1'b0;
      mdio_oe   <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != S_IDLE);
      mdio_done <= 1'b0;
      data_rdy  <= 1'b0;

      if (accept) begin
        frame_q <= t_data;
        shreg   <= '0;
      end

      if (state == S_FRAME && bit_end && is_read && cnt < DATA_BITS)
        shreg <= {shreg[14:0], mdio_in};

      if (state == S_FRAME && last_bit) begin
        mdio_done <= 1'b1;
        if (is_read) begin
          rd_data  <= {shreg[14:0], mdio_in};
          data_rdy <= 1'b1;
        end
      end

      // Line outputs follow the next bit, so they only move when MDC falls.
      unique case (state_nxt)
        S_PREAMBLE: begin
          mdio_out <= 1'b1;
          mdio_oe  <= 1'b1;
        end
        S_FRAME: begin
          if (is_read && cnt_nxt <= TA_BIT) begin
            mdio_out <= 1'b0;
            mdio_oe  <= 1'b0;
          end else begin
            mdio_out <= frame_q[cnt_nxt[4:0]];
            mdio_oe  <= 1'b1;
          end
        end
        default: begin
          mdio_out <= 1'b0;
          mdio_oe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_transmitter.sv
// Directed bench for mdio_transmitter: default preamble DUT plus a 1-bit preamble DUT.
module tb_mdio_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] t_data = 32'h0;
  logic        mdio_in = 1'b1;
  logic        sel = 1'b0;

  logic        mdc0, out0, oe0, rdy0, done0, busy0;
  logic [15:0] rd0;
  logic        mdc1, out1, oe1, rdy1, done1, busy1;
  logic [15:0] rd1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mdio_transmitter #(.PREAMBLE_BITS(32)) dut (
    .clk(clk), .rst(rst), .mdio_start(start0), .t_data(t_data), .mdio_in(mdio_in),
    .mdc(mdc0), .mdio_out(out0), .mdio_oe(oe0), .rd_data(rd0),
    .data_rdy(rdy0), .mdio_done(done0), .busy(busy0)
  );

  mdio_transmitter #(.PREAMBLE_BITS(1)) dut_short (
    .clk(clk), .rst(rst), .mdio_start(start1), .t_data(t_data), .mdio_in(mdio_in),
    .mdc(mdc1), .mdio_out(out1), .mdio_oe(oe1), .rd_data(rd1),
    .data_rdy(rdy1), .mdio_done(done1), .busy(busy1)
  );

  logic [5:0]  s_vec;
  logic [15:0] s_rd;
  assign s_vec = sel ? {mdc1, oe1, out1, busy1, done1, rdy1}
                     : {mdc0, oe0, out0, busy0, done0, rdy0};
  assign s_rd  = sel ? rd1 : rd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else start0 = v;
  endtask

  task automatic accept(input logic [31:0] fr);
    @(negedge clk);
    t_data = fr;
    set_start(1'b1);
  endtask

  // Walks one frame from cycle E0+1 through DONE; vector is {mdc,oe,out,busy,done,rdy}.
  task automatic run_body(input string name, input logic [31:0] fr, input int pb,
                          input logic [15:0] rd, input int ign_k, input bit hold,
                          input logic [31:0] next_data);
    int   n;
    int   b;
    int   fb;
    logic rdf, ph, ee, eo;
    n   = 2 * (pb + 32);
    rdf = (fr[29:28] == 2'b10);
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (!hold) set_start(1'b0);
        t_data = ~fr;
      end
      if (!hold && ign_k > 0) begin
        if (k == ign_k) set_start(1'b1);
        else if (k == ign_k + 1) set_start(1'b0);
      end
      if (k <= n) begin
        b  = (k - 1) / 2;
        ph = ((k - 1) % 2) == 1;
        fb = 31 - (b - pb);
        if (b < pb) begin
          ee = 1'b1; eo = 1'b1;
        end else if (rdf && fb <= 17) begin
          ee = 1'b0; eo = 1'b0;
        end else begin
          ee = 1'b1; eo = fr[fb];
        end
        mdio_in = (rdf && b >= pb && fb <= 15) ? rd[fb] : 1'b1;
        chk($sformatf("%s_c%0d", name, k), 32'(s_vec), 32'({ph, ee, eo, 1'b1, 1'b0, 1'b0}));
      end else begin
        chk($sformatf("%s_done", name), 32'(s_vec), 32'({5'b00011, rdf}));
        if (rdf) chk($sformatf("%s_rd_data", name), 32'(s_rd), 32'(rd));
        if (hold) t_data = next_data;
      end
    end
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    chk(name, 32'(s_vec), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_main", 32'({s_vec, s_rd}), 32'h0);
    sel = 1'b1;
    chk("rst_short", 32'({s_vec, s_rd}), 32'h0);
    sel = 1'b0;
    rst = 1'b0;
    idle_check("idle_after_rst");

    accept(32'h6196_0000);
    run_body("read", 32'h6196_0000, 32, 16'hA5C3, 0, 1'b0, 32'h0);
    idle_check("read_idle");

    accept(32'h5196_BEEF);
    run_body("write", 32'h5196_BEEF, 32, 16'h0, 40, 1'b0, 32'h0);
    idle_check("write_idle");
    chk("rd_held", 32'(s_rd), 32'hA5C3);

    accept(32'h50A5_1234);
    run_body("b2b_w", 32'h50A5_1234, 32, 16'h0, 0, 1'b1, 32'h6ABC_0000);
    run_body("b2b_r", 32'h6ABC_0000, 32, 16'h3C5A, 0, 1'b0, 32'h0);
    idle_check("b2b_idle");

    accept(32'h6196_0000);
    for (int k = 1; k <= 2 * (32 + 21) + 1; k++) begin
      @(negedge clk);
      if (k == 1) set_start(1'b0);
      mdio_in = k[0];
    end
    #2 rst = 1'b1;
    #1 chk("rst_mid_outputs", 32'({s_vec, s_rd}), 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_hold", 32'({s_vec, s_rd}), 32'h0);
    end
    rst = 1'b0;
    idle_check("rst_mid_idle");
    accept(32'h5196_BEEF);
    run_body("post_rst_w", 32'h5196_BEEF, 32, 16'h0, 0, 1'b0, 32'h0);
    idle_check("post_rst_idle");
    chk("post_rst_rd", 32'(s_rd), 32'h0);

    sel = 1'b1;
    accept(32'h5196_BEEF);
    run_body("short_w", 32'h5196_BEEF, 1, 16'h0, 0, 1'b0, 32'h0);
    idle_check("short_idle");
    chk("short_rd", 32'(s_rd), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
